led_seq_ctrl: RTL

Memory-mapped LED sequencer on the core's MMIO bus; drives the 8 board LEDs autonomously.
Software writes a pattern, a step period and a mode; the block's prescaler and step state machine then animate the LEDs with no CPU involvement.

---
 rtl/led_seq_ctrl_if.sv | 24 ++
 rtl/led_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl_if.sv
// MMIO bus bundle shared by the memory-mapped peripherals (re/rd/we/wd/addr[31:2]).
interface led_seq_ctrl_if;
    logic        re;
    logic [31:0] rd;
    logic        we;
    logic [31:0] wd;
    logic [31:2] addr;

    modport master (
        output re,
        output we,
        output wd,
        output addr,
        input  rd
    );

    modport slave (
        input  re,
        input  we,
        input  wd,
        input  addr,
        output rd
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// Memory-mapped LED sequencer: software programs pattern, step period and mode;
// a prescaler and step engine then animate the 8 LEDs autonomously.
module led_seq_ctrl #(
    parameter int unsigned                PERIOD_WIDTH = 24,
    parameter logic [PERIOD_WIDTH-1:0]    RESET_PERIOD = PERIOD_WIDTH'(1_000_000)
) (
    input  logic           clk,
    input  logic           reset,
    led_seq_ctrl_if.slave  bus,
    output logic [7:0]     led
);

    localparam int unsigned LED_W  = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned POS_W  = 3;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Software-visible registers
    mode_e                   mode_q,     mode_d;
    logic                    en_q,       en_d;
    logic [LED_W-1:0]        pattern_q,  pattern_d;
    logic [PERIOD_WIDTH-1:0] period_q,   period_d;

    // Animation state
    logic [PERIOD_WIDTH-1:0] tick_q,     tick_d;
    logic [CNT_W-1:0]        step_cnt_q, step_cnt_d;
    logic [LED_W-1:0]        cur_q,      cur_d;
    logic                    phase_q,    phase_d;
    logic [POS_W-1:0]        pos_q,      pos_d;
    dir_e                    dir_q,      dir_d;
    logic [LED_W-1:0]        led_q,      led_d;

    logic [1:0]              reg_sel;
    logic                    wr_ctrl;
    logic                    wr_pattern;
    logic                    wr_period;
    logic                    restart;
    logic                    running;
    logic [PERIOD_WIDTH-1:0] tick_last;
    logic                    step;
    logic                    unused_bits;

    assign reg_sel    = bus.addr[3:2];
    assign wr_ctrl    = bus.we && (reg_sel == ADDR_CTRL);
    assign wr_pattern = bus.we && (reg_sel == ADDR_PATTERN);
    assign wr_period  = bus.we && (reg_sel == ADDR_PERIOD);
    assign restart    = wr_ctrl || wr_pattern || wr_period;
    assign running    = en_q && (mode_q != MODE_STATIC);

    // PERIOD of zero behaves like one: a step on every cycle.
    assign tick_last  = (period_q == '0) ? '0 : period_q - PERIOD_WIDTH'(1);
    assign step       = running && (tick_q == tick_last);

    // Upper address bits and excess write-data bits are intentionally ignored.
    assign unused_bits = ^{bus.addr[31:4], bus.wd};

    // Register writes, restart, prescaler and per-mode step update
    always_comb begin
        mode_d     = mode_q;
        en_d       = en_q;
        pattern_d  = pattern_q;
        period_d   = period_q;
        tick_d     = tick_q;
        step_cnt_d = step_cnt_q;
        cur_d      = cur_q;
        phase_d    = phase_q;
        pos_d      = pos_q;
        dir_d      = dir_q;

        if (wr_ctrl) begin
            mode_d = mode_e'(bus.wd[1:0]);
            en_d   = bus.wd[2];
        end
        if (wr_pattern) begin
            pattern_d = bus.wd[LED_W-1:0];
        end
        if (wr_period) begin
            period_d = bus.wd[PERIOD_WIDTH-1:0];
        end

        if (restart) begin
            // A restart takes priority over a step due in the same cycle.
            tick_d     = '0;
            step_cnt_d = '0;
            phase_d    = 1'b0;
            pos_d      = '0;
            dir_d      = DIR_UP;
            cur_d      = pattern_d;
        end else if (running) begin
            if (step) begin
                tick_d     = '0;
                step_cnt_d = step_cnt_q + CNT_W'(1);
                unique case (mode_q)
                    MODE_BLINK: begin
                        phase_d = ~phase_q;
                    end
                    MODE_ROTATE: begin
                        cur_d = {cur_q[LED_W-2:0], cur_q[LED_W-1]};
                    end
                    MODE_BOUNCE: begin
                        // Turn around on arrival so each end shows for exactly one step.
                        if (dir_q == DIR_UP) begin
                            pos_d = pos_q + POS_W'(1);
                            if (pos_q == POS_W'(6)) begin
                                dir_d = DIR_DOWN;
                            end
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                            if (pos_q == POS_W'(1)) begin
                                dir_d = DIR_UP;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end else begin
                tick_d = tick_q + PERIOD_WIDTH'(1);
            end
        end
    end

    // LED image from the current state; frozen while an animated mode is disabled
    always_comb begin
        led_d = led_q;
        if (mode_q == MODE_STATIC) begin
            led_d = pattern_q;
        end else if (en_q) begin
            unique case (mode_q)
                MODE_BLINK:  led_d = phase_q ? '0 : cur_q;
                MODE_ROTATE: led_d = cur_q;
                MODE_BOUNCE: led_d = LED_W'(1) << pos_q;
                default:     led_d = led_q;
            endcase
        end
    end

    // Combinational read mux, zero when not reading
    always_comb begin
        bus.rd = '0;
        if (bus.re) begin
            unique case (reg_sel)
                ADDR_CTRL:    bus.rd = {29'd0, en_q, mode_q};
                ADDR_PATTERN: bus.rd = 32'(pattern_q);
                ADDR_PERIOD:  bus.rd = 32'(period_q);
                ADDR_STATUS:  bus.rd = {16'd0, step_cnt_q, led_q};
                default:      bus.rd = '0;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_STATIC;
            en_q       <= 1'b0;
            pattern_q  <= '0;
            period_q   <= RESET_PERIOD;
            tick_q     <= '0;
            step_cnt_q <= '0;
            cur_q      <= '0;
            phase_q    <= 1'b0;
            pos_q      <= '0;
            dir_q      <= DIR_UP;
            led_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            en_q       <= en_d;
            pattern_q  <= pattern_d;
            period_q   <= period_d;
            tick_q     <= tick_d;
            step_cnt_q <= step_cnt_d;
            cur_q      <= cur_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            led_q      <= led_d;
        end
    end

    assign led = led_q;

endmodule
